mdio_phy_slave: RTL and testbench

- PHY-side MDIO management slave: consumes MDC/MDIO_OE/MDIO_OUT from the MDIO controller and returns read data serially.
- Decodes Clause-22 frames and drives a simple register-file port (address, write strobe, read strobe).
- Sits directly downstream of the MDIO controller, in the same clk domain; MDC is generated from clk.

---
 rtl/mdio_phy_slave_pkg.sv | 35 +++
 rtl/mdio_phy_slave_if.sv | 27 ++
 rtl/mdio_phy_slave_edge_det.sv | 24 ++
 rtl/mdio_phy_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_mdio_phy_slave.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_phy_slave_pkg.sv
// Frame constants and state encoding for the Clause-22 MDIO PHY-side slave.
// Bit indices count the frame MSB-first from 0 (first ST bit) to FRAME_BITS-1.
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_SKIP
  } state_e;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam int FRAME_BITS = 32;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef logic [BIT_W-1:0] bit_idx_t;

  // Index of the last bit of each field.
  localparam bit_idx_t ST_END    = bit_idx_t'(1);
  localparam bit_idx_t OP_END    = bit_idx_t'(3);
  localparam bit_idx_t PHYAD_END = bit_idx_t'(8);
  localparam bit_idx_t REGAD_END = bit_idx_t'(13);
  localparam bit_idx_t TA_END    = bit_idx_t'(15);
  localparam bit_idx_t LAST_BIT  = bit_idx_t'(FRAME_BITS - 1);

endpackage

// File: rtl/mdio_phy_slave_if.sv
// MDIO serial bus between the management controller (master) and the PHY slave.
// MDC is a clk-synchronous management clock generated by the controller.
interface mdio_phy_slave_if;

  logic MDC;
  logic MDIO_OE;
  logic MDIO_OUT;
  logic MDIO_RD;
  logic MDIO_RD_OE;

  modport master (
    output MDC,
    output MDIO_OE,
    output MDIO_OUT,
    input  MDIO_RD,
    input  MDIO_RD_OE
  );

  modport slave (
    input  MDC,
    input  MDIO_OE,
    input  MDIO_OUT,
    output MDIO_RD,
    output MDIO_RD_OE
  );

endinterface

// File: rtl/mdio_phy_slave_edge_det.sv
// Rising-edge detector for the clk-synchronous MDC. Flags the clk cycle in
// which MDC is seen high for the first time.
module mdc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic mdc_i,
  output logic rise_o
);

  logic mdc_q;

  // Reset to 1 so an MDC that is already high at reset release gives no edge.
  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q <= 1'b1;
    end else begin
      mdc_q <= mdc_i;
    end
  end

  assign rise_o = mdc_i & ~mdc_q;

endmodule

// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO PHY-side slave: decodes frames on MDC rising edges and drives a
// simple register-file port. Define MDIO_PRE_CHECK_EN to require a preamble.
module mdio_phy_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'h01,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mdio_phy_slave_if.slave        mdio,
  output logic [4:0]             REG_ADDR,
  output logic [15:0]            REG_WDATA,
  output logic                   REG_WE,
  output logic                   REG_RE,
  input  logic [15:0]            REG_RDATA,
  output logic                   BUSY,
  output logic                   FRAME_ERR
);

  logic mdc_rise;
  logic bus_bit;
  logic start_ok;

  mdc_edge_det u_mdc_edge (
    .clk    (clk),
    .rst    (rst),
    .mdc_i  (mdio.MDC),
    .rise_o (mdc_rise)
  );

  // Pulled-up bus: reads 1 whenever the controller is not driving.
  assign bus_bit = mdio.MDIO_OE ? mdio.MDIO_OUT : 1'b1;

  state_e      state_q,   state_d;
  bit_idx_t    bit_cnt_q, bit_cnt_d;
  logic [14:0] shift_q,   shift_d;
  logic [15:0] shadow_q,  shadow_d;
  logic        is_rd_q,   is_rd_d;
  logic        rd_q,      rd_d;
  logic        rd_oe_q,   rd_oe_d;
  logic [4:0]  addr_q,    addr_d;
  logic [15:0] wdata_q,   wdata_d;
  logic        we_q,      we_d;
  logic        re_q,      re_d;
  logic        err_q,     err_d;

`ifdef MDIO_PRE_CHECK_EN
  localparam int               PRE_W   = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_LEN);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // Consecutive idle 1s, saturating; any 0 seen in IDLE clears the run.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    start_ok  = (pre_cnt_q >= PRE_MAX);
    if (mdc_rise && state_q == S_IDLE) begin
      if (bus_bit) begin
        pre_cnt_d = start_ok ? pre_cnt_q : pre_cnt_q + 1'b1;
      end else begin
        pre_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end
`else
  logic unused_preamble_len;
  assign unused_preamble_len = ^PREAMBLE_LEN;
  assign start_ok            = 1'b1;
`endif

  // NOTE: every variable gets its hold/idle value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    is_rd_d   = is_rd_q;
    rd_d      = rd_q;
    rd_oe_d   = rd_oe_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    err_d     = 1'b0;

    if (mdc_rise) begin
      shift_d   = {shift_q[13:0], bus_bit};
      bit_cnt_d = (state_q == S_IDLE) ? '0 : bit_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (!bus_bit && start_ok) begin
            state_d   = S_ST;
            bit_cnt_d = ST_END;
          end
        end

        S_ST: begin
          if ({shift_q[0], bus_bit} == ST_CODE) begin
            state_d = S_OP;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end

        S_OP: begin
          if (bit_cnt_q == OP_END) begin
            case ({shift_q[0], bus_bit})
              OP_WR: begin
                is_rd_d = 1'b0;
                state_d = S_PHYAD;
              end
              OP_RD: begin
                is_rd_d = 1'b1;
                state_d = S_PHYAD;
              end
              default: begin
                err_d   = 1'b1;
                state_d = S_SKIP;
              end
            endcase
          end
        end

        // A frame for another PHY is skipped without any visible reaction.
        S_PHYAD: begin
          if (bit_cnt_q == PHYAD_END) begin
            state_d = ({shift_q[3:0], bus_bit} == PHY_ADDR) ? S_REGAD : S_SKIP;
          end
        end

        S_REGAD: begin
          if (bit_cnt_q == REGAD_END) begin
            addr_d  = {shift_q[3:0], bus_bit};
            re_d    = is_rd_q;
            state_d = S_TA;
          end
        end

        // Read: first TA bit captures the register data and drives the
        // turnaround 0; the second TA bit already carries the data MSB.
        S_TA: begin
          if (is_rd_q) begin
            if (bit_cnt_q == TA_END) begin
              rd_d     = shadow_q[15];
              shadow_d = {shadow_q[14:0], 1'b0};
              state_d  = S_RDATA;
            end else begin
              shadow_d = REG_RDATA;
              rd_oe_d  = 1'b1;
              rd_d     = 1'b0;
            end
          end else if (bit_cnt_q == TA_END) begin
            if ({shift_q[0], bus_bit} == TA_WR) begin
              state_d = S_WDATA;
            end else begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end
          end
        end

        S_RDATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            rd_oe_d = 1'b0;
            rd_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            rd_d     = shadow_q[15];
            shadow_d = {shadow_q[14:0], 1'b0};
          end
        end

        S_WDATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            wdata_d = {shift_q, bus_bit};
            we_d    = 1'b1;
            state_d = S_IDLE;
          end
        end

        S_SKIP: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      shadow_q  <= '0;
      is_rd_q   <= 1'b0;
      rd_q      <= 1'b0;
      rd_oe_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      is_rd_q   <= is_rd_d;
      rd_q      <= rd_d;
      rd_oe_q   <= rd_oe_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      err_q     <= err_d;
    end
  end

  assign mdio.MDIO_RD    = rd_q;
  assign mdio.MDIO_RD_OE = rd_oe_q;
  assign REG_ADDR        = addr_q;
  assign REG_WDATA       = wdata_q;
  assign REG_WE          = we_q;
  assign REG_RE          = re_q;
  assign FRAME_ERR       = err_q;
  assign BUSY            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Scoreboard bench for mdio_phy_slave: randomized Clause-22 frames, a frame-level
// reference model feeding expectation queues, and a passive output monitor.
module tb_mdio_phy_slave;

`ifdef MDIO_PRE_CHECK_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif
  localparam logic [4:0] PHY     = 5'h01;
  localparam int         PRE_LEN = 32;

  typedef enum logic [1:0] {EV_WE, EV_RE, EV_ERR} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    logic        st1;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
    int          pre;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        busy;
  logic        frame_err;

  ev_t         ev_q[$];
  logic [16:0] rd_q[$];
  logic [15:0] rf_mem[32];
  int          n_checks = 0;
  int          n_fail   = 0;

  mdio_phy_slave_if bus ();

  mdio_phy_slave #(
    .PHY_ADDR     (PHY),
    .PREAMBLE_LEN (PRE_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mdio      (bus),
    .REG_ADDR  (reg_addr),
    .REG_WDATA (reg_wdata),
    .REG_WE    (reg_we),
    .REG_RE    (reg_re),
    .REG_RDATA (reg_rdata),
    .BUSY      (busy),
    .FRAME_ERR (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One MDC period: 2 clk low (data set up), 2 clk high.
  task automatic drive_bit(input logic oe, input logic val);
    bus.MDC      = 1'b0;
    bus.MDIO_OE  = oe;
    bus.MDIO_OUT = val;
    wait_clks(2);
    bus.MDC = 1'b1;
    wait_clks(2);
  endtask

  function automatic frame_t mk(input logic st1, input logic [1:0] op, input logic [4:0] phyad,
                                input logic [4:0] regad, input logic [1:0] ta,
                                input logic [15:0] data, input int pre);
    frame_t f;
    f.st1 = st1; f.op = op; f.phyad = phyad; f.regad = regad;
    f.ta = ta; f.data = data; f.pre = pre;
    return f;
  endfunction

  // Controller side: preamble (bus released), then 32 frame bits; a read
  // frame releases the bus from the first TA bit onward.
  task automatic send_frame(input frame_t f, input int abort_after);
    logic [31:0] b;
    logic        rel;
    b = {1'b0, f.st1, f.op, f.phyad, f.regad, f.ta, f.data};
    for (int i = 0; i < f.pre; i++) drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rel = (f.op == 2'b10) && (i >= 14);
      drive_bit(!rel, b[31-i]);
      if (i == abort_after) return;
    end
  endtask

  // Reference model: what the register port should see for a whole frame.
  task automatic expect_frame(input frame_t f, input bit aborted);
    ev_t e;
    e.addr = f.regad;
    e.data = f.data;
    if (PRE_EN && f.pre < PRE_LEN) return;
    if (f.st1 != 1'b1 || f.op == 2'b00 || f.op == 2'b11) begin
      e.kind = EV_ERR;
      ev_q.push_back(e);
    end else if (f.phyad != PHY) begin
      return;
    end else if (f.op == 2'b10) begin
      e.kind = EV_RE;
      ev_q.push_back(e);
      if (!aborted) rd_q.push_back({1'b0, rf_mem[f.regad]});
    end else if (f.ta != 2'b10) begin
      e.kind = EV_ERR;
      ev_q.push_back(e);
    end else begin
      e.kind = EV_WE;
      ev_q.push_back(e);
    end
  endtask

  task automatic run_frame(input frame_t f);
    expect_frame(f, 1'b0);
    send_frame(f, 99);
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  // Register file: read data valid one clk after REG_RE.
  initial begin
    reg_rdata = '0;
    forever begin
      @(posedge clk);
      if (reg_re) reg_rdata <= rf_mem[reg_addr];
    end
  end

  // Monitor: pops the scoreboard on every strobe and on every read response.
  initial begin
    ev_t         e;
    logic [16:0] rbits;
    logic [16:0] exp_bits;
    int          rn;
    logic        oe_prev;
    logic        mdc_prev;
    rbits = '0; rn = 0; oe_prev = 1'b0; mdc_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        rbits = '0; rn = 0; oe_prev = 1'b0; mdc_prev = bus.MDC;
      end else begin
        if (reg_we || reg_re || frame_err) begin
          check("event_expected", 32'(ev_q.size() > 0), 32'd1);
          if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            check("event_kind", {29'd0, reg_we, reg_re, frame_err},
                  (e.kind == EV_WE) ? 32'd4 : (e.kind == EV_RE) ? 32'd2 : 32'd1);
            if (e.kind != EV_ERR) check("event_addr", 32'(reg_addr), 32'(e.addr));
            if (e.kind == EV_WE)  check("write_data", 32'(reg_wdata), 32'(e.data));
          end
        end
        if (mdc_prev && !bus.MDC && bus.MDIO_RD_OE) begin
          rbits = {rbits[15:0], bus.MDIO_RD};
          rn++;
        end
        if (oe_prev && !bus.MDIO_RD_OE) begin
          check("read_expected", 32'(rd_q.size() > 0), 32'd1);
          if (rd_q.size() > 0) begin
            exp_bits = rd_q.pop_front();
            check("read_serial", 32'(rbits), 32'(exp_bits));
            check("read_oe_periods", 32'(rn), 32'd17);
          end
          rbits = '0;
          rn    = 0;
        end
        oe_prev  = bus.MDIO_RD_OE;
        mdc_prev = bus.MDC;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    frame_t f;
    int     dpre;
    int     pick;
    dpre = PRE_EN ? PRE_LEN : 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 16'($urandom);
    rf_mem[5] = 16'h8FF1;

    bus.MDC = 1'b1; bus.MDIO_OE = 1'b0; bus.MDIO_OUT = 1'b0;
    wait_clks(4);
    check("rst_reg_addr",  32'(reg_addr),       32'd0);
    check("rst_reg_wdata", 32'(reg_wdata),      32'd0);
    check("rst_reg_we",    32'(reg_we),         32'd0);
    check("rst_reg_re",    32'(reg_re),         32'd0);
    check("rst_busy",      32'(busy),           32'd0);
    check("rst_frame_err", 32'(frame_err),      32'd0);
    check("rst_rd",        32'(bus.MDIO_RD),    32'd0);
    check("rst_rd_oe",     32'(bus.MDIO_RD_OE), 32'd0);
    rst = 1'b0;
    wait_clks(3);

    run_frame(mk(1'b1, 2'b01, PHY,   5'd3, 2'b10, 16'hBEEF, dpre));
    run_frame(mk(1'b1, 2'b10, PHY,   5'd5, 2'b00, 16'h0000, dpre));
    run_frame(mk(1'b1, 2'b01, 5'h02, 5'd7, 2'b10, 16'h1234, dpre));
    run_frame(mk(1'b1, 2'b01, PHY,   5'd7, 2'b10, 16'h5A5A, dpre));
    run_frame(mk(1'b1, 2'b11, PHY,   5'd2, 2'b10, 16'hFFFF, dpre));
    run_frame(mk(1'b1, 2'b01, PHY,   5'd2, 2'b01, 16'hA5A5, dpre));
    run_frame(mk(1'b0, 2'b01, PHY,   5'd4, 2'b10, 16'h0F0F, dpre));

    // Reset in the middle of a read response, MDC left high across release.
    f = mk(1'b1, 2'b10, PHY, 5'd12, 2'b00, 16'h0000, dpre);
    expect_frame(f, 1'b1);
    send_frame(f, 20);
    check("busy_mid_read",  32'(busy),           32'd1);
    check("rd_oe_mid_read", 32'(bus.MDIO_RD_OE), 32'd1);
    rst = 1'b1; bus.MDIO_OE = 1'b1; bus.MDIO_OUT = 1'b0;
    wait_clks(1);
    check("rd_oe_after_rst", 32'(bus.MDIO_RD_OE), 32'd0);
    check("busy_after_rst",  32'(busy),           32'd0);
    check("re_after_rst",    32'(reg_re),         32'd0);
    wait_clks(2);
    rst = 1'b0;
    wait_clks(6);
    check("busy_no_spurious", 32'(busy), 32'd0);
    run_frame(mk(1'b1, 2'b01, PHY, 5'd9, 2'b10, 16'hC3C3, dpre));

    // Short and full preambles.
    run_frame(mk(1'b1, 2'b01, PHY, 5'd10, 2'b10, 16'h1111, 10));
    run_frame(mk(1'b1, 2'b01, PHY, 5'd11, 2'b10, 16'h2222, 32));

    for (int n = 0; n < 40; n++) begin
      f.st1   = ($urandom_range(0, 9) != 0);
      f.op    = 2'($urandom_range(0, 3));
      f.phyad = ($urandom_range(0, 4) != 0) ? PHY : 5'($urandom);
      f.regad = 5'($urandom);
      f.ta    = ($urandom_range(0, 9) != 0) ? 2'b10 : 2'($urandom);
      f.data  = 16'($urandom);
      pick    = int'($urandom_range(0, 3));
      if (PRE_EN) f.pre = PRE_LEN + pick * 2;
      else        f.pre = (pick < 2) ? 0 : (pick == 2) ? 3 : 32;
      run_frame(f);
    end

    wait_clks(10);
    check("events_drained", 32'(ev_q.size()), 32'd0);
    check("reads_drained",  32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
